// File: rtl/oc8051_ifetch.sv
// oc8051 instruction fetch: issues program addresses to the registered ROM,
// decodes the MCS-51 instruction length and hands one instruction per handshake.
module oc8051_ifetch #(
  parameter logic [15:0] RESET_VEC = 16'h0000,
  parameter int unsigned EXT_WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] rom_addr,
  input  logic        rom_ea_int,
  input  logic [7:0]  rom_data1,
  input  logic [7:0]  rom_data2,
  input  logic [7:0]  rom_data3,
  input  logic        jmp_req,
  input  logic [15:0] jmp_addr,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [7:0]  op1,
  output logic [7:0]  op2,
  output logic [7:0]  op3,
  output logic [1:0]  ins_len,
  output logic [15:0] ins_pc
);

  localparam logic [1:0] S_ISSUE   = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  localparam logic       NO_WAIT   = (EXT_WAIT == 32'd0);
  localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(EXT_WAIT - 32'd1);

  // Full MCS-51 length map, organised by low nibble then high nibble.
  function automatic logic [1:0] len_decode(input logic [7:0] op);
    logic [3:0] hi;
    logic [3:0] lo;
    logic [1:0] len;
    hi  = op[7:4];
    lo  = op[3:0];
    len = 2'd1;
    case (lo)
      4'h0: begin
        case (hi)
          4'h1, 4'h2, 4'h3, 4'h9: len = 2'd3;
          4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
          4'hA, 4'hB, 4'hC, 4'hD: len = 2'd2;
          default:                len = 2'd1;
        endcase
      end
      4'h1: len = 2'd2;
      4'h2: begin
        case (hi)
          4'h0, 4'h1:             len = 2'd3;
          4'h2, 4'h3, 4'hE, 4'hF: len = 2'd1;
          default:                len = 2'd2;
        endcase
      end
      4'h3: begin
        case (hi)
          4'h4, 4'h5, 4'h6: len = 2'd3;
          default:          len = 2'd1;
        endcase
      end
      4'h4: begin
        case (hi)
          4'h2, 4'h3, 4'h4, 4'h5,
          4'h6, 4'h7, 4'h9: len = 2'd2;
          4'hB:             len = 2'd3;
          default:          len = 2'd1;
        endcase
      end
      4'h5: begin
        case (hi)
          4'h7, 4'h8, 4'hB, 4'hD: len = 2'd3;
          4'hA:                   len = 2'd1;
          default:                len = 2'd2;
        endcase
      end
      4'h6, 4'h7: begin
        case (hi)
          4'h7, 4'h8, 4'hA: len = 2'd2;
          4'hB:             len = 2'd3;
          default:          len = 2'd1;
        endcase
      end
      default: begin
        case (hi)
          4'h7, 4'h8, 4'hA, 4'hD: len = 2'd2;
          4'hB:                   len = 2'd3;
          default:                len = 2'd1;
        endcase
      end
    endcase
    return len;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [7:0]  op1_q, op1_d;
  logic [7:0]  op2_q, op2_d;
  logic [7:0]  op3_q, op3_d;
  logic [1:0]  len_q, len_d;
  logic [15:0] ins_pc_q, ins_pc_d;
  logic [1:0]  cap_len_s;

  assign cap_len_s = len_decode(rom_data1);

  // Next-state logic: jump redirect first, then the fetch sequence.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    op3_d    = op3_q;
    len_d    = len_q;
    ins_pc_d = ins_pc_q;
    if (jmp_req) begin
      pc_d    = jmp_addr;
      cnt_d   = 4'd0;
      valid_d = 1'b0;
      state_d = S_ISSUE;
    end else begin
      case (state_q)
        S_ISSUE: begin
          if (rom_ea_int || NO_WAIT) begin
            state_d = S_CAPTURE;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_d = S_CAPTURE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_CAPTURE: begin
          op1_d    = rom_data1;
          op2_d    = (cap_len_s >= 2'd2) ? rom_data2 : 8'h00;
          op3_d    = (cap_len_s == 2'd3) ? rom_data3 : 8'h00;
          len_d    = cap_len_s;
          ins_pc_d = pc_q;
          valid_d  = 1'b1;
          state_d  = S_HOLD;
        end
        S_HOLD: begin
          // pc arithmetic wraps naturally at 16 bits.
          if (valid_q && ins_ready) begin
            pc_d    = pc_q + {14'd0, len_q};
            valid_d = 1'b0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_HOLD;
          end
        end
        default: begin
          state_d = S_ISSUE;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_ISSUE;
      pc_q     <= RESET_VEC;
      cnt_q    <= 4'd0;
      valid_q  <= 1'b0;
      op1_q    <= 8'h00;
      op2_q    <= 8'h00;
      op3_q    <= 8'h00;
      len_q    <= 2'd0;
      ins_pc_q <= RESET_VEC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      op3_q    <= op3_d;
      len_q    <= len_d;
      ins_pc_q <= ins_pc_d;
    end
  end

  // The ROM address is the pc flop itself.
  assign rom_addr  = pc_q;
  assign ins_valid = valid_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign op3       = op3_q;
  assign ins_len   = len_q;
  assign ins_pc    = ins_pc_q;

endmodule

// File: tb/tb_oc8051_ifetch.sv
// Directed bench for oc8051_ifetch with a registered ROM model behind it.
module tb_oc8051_ifetch;

  logic        clk;
  logic        rst;
  logic [15:0] rom_addr;
  logic        rom_ea_int;
  logic [7:0]  rom_data1, rom_data2, rom_data3;
  logic        jmp_req;
  logic [15:0] jmp_addr;
  logic        ins_valid;
  logic        ins_ready;
  logic [7:0]  op1, op2, op3;
  logic [1:0]  ins_len;
  logic [15:0] ins_pc;

  logic [7:0] mem [0:65535];
  int checks;
  int failures;
  int n;

  oc8051_ifetch #(.RESET_VEC(16'h0000), .EXT_WAIT(3)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_ea_int(rom_ea_int),
    .rom_data1(rom_data1), .rom_data2(rom_data2), .rom_data3(rom_data3),
    .jmp_req(jmp_req), .jmp_addr(jmp_addr), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .op1(op1), .op2(op2), .op3(op3),
    .ins_len(ins_len), .ins_pc(ins_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered program ROM: bytes appear one clock after the address is sampled.
  always @(posedge clk) begin
    rom_data1 <= mem[rom_addr];
    rom_data2 <= mem[rom_addr + 16'd1];
    rom_data3 <= mem[rom_addr + 16'd2];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until ins_valid is seen; cnt is the number of clock edges taken.
  task automatic run_to_valid(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt = cnt + 1;
    end while (!ins_valid && cnt < 30);
  endtask

  task automatic check_ins(input string tag, input logic [15:0] pc, input logic [1:0] len,
                           input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    check_eq({tag, "_valid"}, 32'(ins_valid), 32'd1);
    check_eq({tag, "_pc"},    32'(ins_pc),    32'(pc));
    check_eq({tag, "_len"},   32'(ins_len),   32'(len));
    check_eq({tag, "_op1"},   32'(op1),       32'(b1));
    check_eq({tag, "_op2"},   32'(op2),       32'(b2));
    check_eq({tag, "_op3"},   32'(op3),       32'(b3));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(ins_valid), 32'd0);
    check_eq({tag, "_op1"},   32'(op1),       32'd0);
    check_eq({tag, "_op2"},   32'(op2),       32'd0);
    check_eq({tag, "_op3"},   32'(op3),       32'd0);
    check_eq({tag, "_len"},   32'(ins_len),   32'd0);
    check_eq({tag, "_pc"},    32'(ins_pc),    32'h0000);
    check_eq({tag, "_addr"},  32'(rom_addr),  32'h0000);
  endtask

  typedef struct {
    logic [15:0] pc;
    logic [1:0]  len;
    logic [7:0]  b1, b2, b3;
  } exp_t;

  exp_t prog_exp [7];
  logic [7:0] dec_op  [12];
  logic [1:0] dec_len [12];

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'h85; mem[1] = 8'hD0; mem[2] = 8'h90; mem[3] = 8'h00;
    mem[4] = 8'h00; mem[5] = 8'h01; mem[6] = 8'h03; mem[7] = 8'hE4;
    mem[8] = 8'hF8; mem[9] = 8'h7C; mem[10] = 8'h40;
    mem[16'hFFFE] = 8'h75; mem[16'hFFFF] = 8'hAA;

    prog_exp[0] = '{16'h0000, 2'd3, 8'h85, 8'hD0, 8'h90};
    prog_exp[1] = '{16'h0003, 2'd1, 8'h00, 8'h00, 8'h00};
    prog_exp[2] = '{16'h0004, 2'd1, 8'h00, 8'h00, 8'h00};
    prog_exp[3] = '{16'h0005, 2'd2, 8'h01, 8'h03, 8'h00};
    prog_exp[4] = '{16'h0007, 2'd1, 8'hE4, 8'h00, 8'h00};
    prog_exp[5] = '{16'h0008, 2'd1, 8'hF8, 8'h00, 8'h00};
    prog_exp[6] = '{16'h0009, 2'd2, 8'h7C, 8'h40, 8'h00};

    dec_op = '{8'hB5, 8'hA5, 8'hD5, 8'h10, 8'h43, 8'hB6,
               8'hD8, 8'h86, 8'h22, 8'hE0, 8'h91, 8'h24};
    dec_len = '{2'd3, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3,
                2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2};

    rst = 1'b1; rom_ea_int = 1'b1; jmp_req = 1'b0; jmp_addr = 16'h0000; ins_ready = 1'b1;
    step(); step();
    check_reset_outputs("reset");

    // Straight-line program with the decoder always ready.
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      run_to_valid(n);
      check_eq($sformatf("seq%0d_lat", i), 32'(n), (i == 0) ? 32'd2 : 32'd3);
      check_ins($sformatf("seq%0d", i), prog_exp[i].pc, prog_exp[i].len,
                prog_exp[i].b1, prog_exp[i].b2, prog_exp[i].b3);
    end

    // Backpressure at pc 0000.
    ins_ready = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    run_to_valid(n);
    check_eq("bp_lat", 32'(n), 32'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      check_ins($sformatf("bp_hold%0d", i), 16'h0000, 2'd3, 8'h85, 8'hD0, 8'h90);
      check_eq($sformatf("bp_addr%0d", i), 32'(rom_addr), 32'h0000);
    end
    ins_ready = 1'b1;
    run_to_valid(n);
    check_eq("bp_rel_lat", 32'(n), 32'd3);
    check_ins("bp_rel", 16'h0003, 2'd1, 8'h00, 8'h00, 8'h00);

    // Jump coinciding with the handshake at pc 0003.
    jmp_req = 1'b1; jmp_addr = 16'h0009;
    step();
    jmp_req = 1'b0;
    check_eq("jmp_valid0", 32'(ins_valid), 32'd0);
    check_eq("jmp_addr", 32'(rom_addr), 32'h0009);
    run_to_valid(n);
    check_eq("jmp_lat", 32'(n), 32'd2);
    check_ins("jmp", 16'h0009, 2'd2, 8'h7C, 8'h40, 8'h00);

    // Held jump request keeps re-issuing with nothing presented.
    jmp_req = 1'b1; jmp_addr = 16'h0005;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("jmphold_valid%0d", i), 32'(ins_valid), 32'd0);
    end
    jmp_req = 1'b0; ins_ready = 1'b0;
    run_to_valid(n);
    check_eq("jmphold_lat", 32'(n), 32'd2);
    check_ins("jmphold", 16'h0005, 2'd2, 8'h01, 8'h03, 8'h00);

    // External fetches with three wait states.
    rom_ea_int = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    run_to_valid(n);
    check_eq("ext_lat0", 32'(n), 32'd5);
    check_ins("ext0", 16'h0000, 2'd3, 8'h85, 8'hD0, 8'h90);
    ins_ready = 1'b1;
    run_to_valid(n);
    check_eq("ext_lat1", 32'(n), 32'd6);
    check_ins("ext1", 16'h0003, 2'd1, 8'h00, 8'h00, 8'h00);
    step();
    ins_ready = 1'b0;
    check_eq("ext_addr4", 32'(rom_addr), 32'h0004);
    step(); step();
    jmp_req = 1'b1; jmp_addr = 16'h0009;
    step();
    jmp_req = 1'b0;
    check_eq("extjmp_addr", 32'(rom_addr), 32'h0009);
    step();
    rom_ea_int = 1'b1;
    run_to_valid(n);
    check_eq("extjmp_lat", 32'(n), 32'd4);
    check_ins("extjmp", 16'h0009, 2'd2, 8'h7C, 8'h40, 8'h00);

    // Wrap-around at the top of the address space.
    jmp_req = 1'b1; jmp_addr = 16'hFFFE;
    step();
    jmp_req = 1'b0;
    run_to_valid(n);
    check_eq("wrap_lat", 32'(n), 32'd2);
    check_ins("wrap", 16'hFFFE, 2'd3, 8'h75, 8'hAA, 8'h85);
    ins_ready = 1'b1;
    step();
    ins_ready = 1'b0;
    check_eq("wrap_addr", 32'(rom_addr), 32'h0001);
    run_to_valid(n);
    check_ins("wrap_next", 16'h0001, 2'd2, 8'hD0, 8'h90, 8'h00);

    // Reset mid-HOLD, with a competing jump that reset must override.
    rst = 1'b1; jmp_req = 1'b1; jmp_addr = 16'h0009;
    step();
    rst = 1'b0; jmp_req = 1'b0;
    check_reset_outputs("rst_hold");
    run_to_valid(n);
    check_eq("rst_hold_lat", 32'(n), 32'd2);
    check_ins("rst_hold_re", 16'h0000, 2'd3, 8'h85, 8'hD0, 8'h90);

    // Reset mid-WAIT.
    rom_ea_int = 1'b0; ins_ready = 1'b1;
    step(); step();
    ins_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0; rom_ea_int = 1'b1;
    check_reset_outputs("rst_wait");
    run_to_valid(n);
    check_eq("rst_wait_lat", 32'(n), 32'd2);
    check_ins("rst_wait_re", 16'h0000, 2'd3, 8'h85, 8'hD0, 8'h90);

    // Length decode spot checks, with op2/op3 masking.
    mem[16'h0101] = 8'h11; mem[16'h0102] = 8'h22;
    for (int i = 0; i < 12; i++) begin
      mem[16'h0100] = dec_op[i];
      jmp_req = 1'b1; jmp_addr = 16'h0100;
      step();
      jmp_req = 1'b0;
      run_to_valid(n);
      check_ins($sformatf("dec_%02h", dec_op[i]), 16'h0100, dec_len[i], dec_op[i],
                (dec_len[i] >= 2'd2) ? 8'h11 : 8'h00, (dec_len[i] == 2'd3) ? 8'h22 : 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
